seven_segment_scanner: RTL and testbench

Time-multiplexed display controller that drives one shared hex-to-7-segment decoder across `NUM_DIGITS` common-anode digits. It holds a hex value (e.g. PC or a debug register from the multicycle MIPS datapath), presents one nibble per refresh slot on `digit_code` for the decoder, and drives the matching active-low digit enable. New values enter through a load/ack handshake and are committed only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/seven_segment_scanner.sv | 115 +++++++++++
 tb/tb_seven_segment_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex display scanner: one shared 7-segment decoder driven across NUM_DIGITS
// common-anode digits, with frame-aligned value updates through a load/ack handshake.
module seven_segment_scanner #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    lz_blank,
   output logic [3:0]              digit_code,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    ack,
   output logic                    frame_done
);

   localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] GUARD_CNT = DIV_W'(GUARD);

   logic [DIV_W-1:0]        div_q, div_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shown_q, shown_d;
   logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
   logic                    pend_valid_q, pend_valid_d;

   logic [3:0]              code_d;
   logic [NUM_DIGITS-1:0]   en_d;
   logic                    ack_d;
   logic                    frame_done_d;

   logic                    tc;
   logic                    frame_end;

   assign tc        = (div_q == DIV_LAST);
   assign frame_end = tc && (idx_q == IDX_LAST);

   // Slot timing and the load/commit handshake; a load in the commit cycle stays pending.
   always_comb begin
      div_d        = div_q + 1'b1;
      idx_d        = idx_q;
      shown_d      = shown_q;
      pending_d    = pending_q;
      pend_valid_d = pend_valid_q;
      if (tc) begin
         div_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (frame_end && pend_valid_q) begin
         shown_d      = pending_q;
         pend_valid_d = 1'b0;
      end
      if (load) begin
         pending_d    = value;
         pend_valid_d = 1'b1;
      end
   end

   // Per-slot digit selection and darkening (mask, leading-zero run, guard band).
   always_comb begin
      logic zero_run;
      logic dark;
      logic [NUM_DIGITS-1:0] en_sel;
      zero_run     = 1'b1;
      dark         = (div_q < GUARD_CNT);
      en_sel       = '1;
      code_d       = 4'h0;
      // Walk from the most significant nibble down so zero_run covers nibbles k..top.
      for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
         zero_run = zero_run & (shown_q[4*k +: 4] == 4'h0);
         if (idx_q == IDX_W'(k)) begin
            code_d    = shown_q[4*k +: 4];
            en_sel[k] = 1'b0;
            if (blank_mask[k] || (lz_blank && zero_run && (k > 0))) begin
               dark = 1'b1;
            end
         end
      end
      en_d         = dark ? '1 : en_sel;
      ack_d        = frame_end && pend_valid_q;
      frame_done_d = frame_end;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q        <= '0;
         idx_q        <= '0;
         shown_q      <= '0;
         pending_q    <= '0;
         pend_valid_q <= 1'b0;
         digit_code   <= 4'h0;
         digit_en     <= '1;
         ack          <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         shown_q      <= shown_d;
         pending_q    <= pending_d;
         pend_valid_q <= pend_valid_d;
         digit_code   <= code_d;
         digit_en     <= en_d;
         ack          <= ack_d;
         frame_done   <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: cycle-count based display model plus directed scenarios.
module tb_seven_segment_scanner;

   localparam int ND    = 4;
   localparam int RDIV  = 4;
   localparam int GUARD = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load = 1'b0;
   logic [15:0]   value = 16'h0;
   logic [3:0]    blank_mask = 4'h0;
   logic          lz_blank = 1'b0;
   logic [3:0]    digit_code;
   logic [3:0]    digit_en;
   logic          ack;
   logic          frame_done;

   seven_segment_scanner #(
      .NUM_DIGITS (ND),
      .REFRESH_DIV(RDIV),
      .GUARD      (GUARD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .value     (value),
      .blank_mask(blank_mask),
      .lz_blank  (lz_blank),
      .digit_code(digit_code),
      .digit_en  (digit_en),
      .ack       (ack),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ack_cnt = 0;
   int base;
   bit check_en = 1'b0;

   // Model state: what is displayed and what is waiting, plus expected registered outputs.
   logic [15:0] m_shown, m_pend;
   bit          m_pv;
   logic [3:0]  exp_code, exp_en;
   logic        exp_ack, exp_fd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   task automatic model_reset();
      m_shown  = 16'h0;
      m_pend   = 16'h0;
      m_pv     = 1'b0;
      exp_code = 4'h0;
      exp_en   = 4'hF;
      exp_ack  = 1'b0;
      exp_fd   = 1'b0;
   endtask

   // One clock: predict outputs from slot arithmetic on the cycle count, then advance.
   task automatic tick();
      int d, i;
      logic bnd, dark, na, ld;
      logic [3:0] nc, ne;
      logic [15:0] lv;
      d    = cyc % RDIV;
      i    = (cyc / RDIV) % ND;
      bnd  = (d == RDIV - 1) && (i == ND - 1);
      nc   = m_shown[4*i +: 4];
      dark = blank_mask[i] || (lz_blank && i > 0 && ((m_shown >> (4*i)) == 16'h0)) || (d < GUARD);
      ne   = dark ? 4'hF : ~(4'b0001 << i);
      na   = bnd && m_pv;
      ld   = load;
      lv   = value;
      @(posedge clk);
      exp_code = nc;
      exp_en   = ne;
      exp_ack  = na;
      exp_fd   = bnd;
      if (na) begin
         m_shown = m_pend;
         m_pv    = 1'b0;
      end
      if (ld) begin
         m_pend = lv;
         m_pv   = 1'b1;
      end
      cyc++;
      #1;
      if (ack) ack_cnt++;
   endtask

   // After run_to(n) the outputs reflect internal cycle n.
   task automatic run_to(input int n);
      while (cyc <= n) tick();
   endtask

   task automatic load_at(input int n, input logic [15:0] v);
      run_to(n - 1);
      load  = 1'b1;
      value = v;
      run_to(n);
      load  = 1'b0;
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("cmp_code", 32'(digit_code), 32'(exp_code));
         chk("cmp_en", 32'(digit_en), 32'(exp_en));
         chk("cmp_ack", 32'(ack), 32'(exp_ack));
         chk("cmp_frame_done", 32'(frame_done), 32'(exp_fd));
      end
   end

   initial begin
      model_reset();
      check_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_en", 32'(digit_en), 32'hF);
      chk("rst_code", 32'(digit_code), 32'h0);
      rst = 1'b1;
      cyc = 0;

      // Idle frame: guard then lit, digit by digit.
      run_to(0);  chk("idle_guard_en", 32'(digit_en), 32'hF);
      run_to(1);  chk("idle_d0_en", 32'(digit_en), 32'hE);
      run_to(5);  chk("idle_d1_en", 32'(digit_en), 32'hD);
      run_to(14); chk("idle_fd_early", 32'(frame_done), 32'h0);
      run_to(15); chk("idle_d3_en", 32'(digit_en), 32'h7);
      chk("idle_fd", 32'(frame_done), 32'h1);
      chk("idle_no_ack", 32'(ack_cnt), 32'h0);

      // Mid-frame load commits only at the boundary.
      load_at(22, 16'h12AF);
      run_to(29); chk("ld_old_code", 32'(digit_code), 32'h0);
      run_to(31); chk("ld_ack", 32'(ack), 32'h1);
      run_to(33); chk("ld_d0_code", 32'(digit_code), 32'hF); chk("ld_d0_en", 32'(digit_en), 32'hE);
      run_to(37); chk("ld_d1_code", 32'(digit_code), 32'hA); chk("ld_d1_en", 32'(digit_en), 32'hD);
      run_to(41); chk("ld_d2_code", 32'(digit_code), 32'h2); chk("ld_d2_en", 32'(digit_en), 32'hB);
      run_to(45); chk("ld_d3_code", 32'(digit_code), 32'h1); chk("ld_d3_en", 32'(digit_en), 32'h7);

      // Two loads in one frame: latest wins, single ack.
      base = ack_cnt;
      load_at(50, 16'h1111);
      load_at(54, 16'h2222);
      run_to(63); chk("ow_ack", 32'(ack), 32'h1);
      run_to(65); chk("ow_code", 32'(digit_code), 32'h2);
      run_to(79); chk("ow_ack_count", 32'(ack_cnt - base), 32'h1);

      // Leading-zero blanking, then blank_mask on digit 0.
      lz_blank = 1'b1;
      load_at(82, 16'h0030);
      run_to(97);  chk("lz_d0_en", 32'(digit_en), 32'hE); chk("lz_d0_code", 32'(digit_code), 32'h0);
      run_to(101); chk("lz_d1_en", 32'(digit_en), 32'hD); chk("lz_d1_code", 32'(digit_code), 32'h3);
      run_to(105); chk("lz_d2_en", 32'(digit_en), 32'hF);
      run_to(109); chk("lz_d3_en", 32'(digit_en), 32'hF);
      run_to(111);
      blank_mask = 4'b0001;
      run_to(113); chk("bm_d0_en", 32'(digit_en), 32'hF);
      run_to(117); chk("bm_d1_en", 32'(digit_en), 32'hD);
      run_to(127);
      blank_mask = 4'b0000;
      lz_blank   = 1'b0;

      // Load in the boundary cycle while another value is pending.
      load_at(130, 16'hBEEF);
      load_at(143, 16'hC0DE);
      chk("bnd_ack1", 32'(ack), 32'h1);
      run_to(145); chk("bnd_old_code", 32'(digit_code), 32'hF);
      run_to(158); chk("bnd_no_ack", 32'(ack), 32'h0);
      run_to(159); chk("bnd_ack2", 32'(ack), 32'h1);
      run_to(161); chk("bnd_new_d0", 32'(digit_code), 32'hE);
      run_to(165); chk("bnd_new_d1", 32'(digit_code), 32'hD);

      // Reset mid-slot with a value pending.
      load_at(166, 16'h5A5A);
      run_to(169);
      rst = 1'b0;
      model_reset();
      #1;
      chk("mr_en", 32'(digit_en), 32'hF);
      chk("mr_code", 32'(digit_code), 32'h0);
      chk("mr_ack", 32'(ack), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
      base = ack_cnt;
      run_to(15); chk("mr_fd", 32'(frame_done), 32'h1); chk("mr_no_ack", 32'(ack), 32'h0);
      run_to(17); chk("mr_code_zero", 32'(digit_code), 32'h0);
      run_to(40); chk("mr_ack_count", 32'(ack_cnt - base), 32'h0);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
